cond_unit_pred: RTL
===================

# cond_unit_pred

Parametrised Execute-stage condition unit for the pipelined core: holds NZCV flags in `NBANKS` independent banks and evaluates the full 4-bit condition field against the selected bank. It gates register, memory and branch writes, and opens a post-branch squash window of `FLUSH_CYC` cycles. It also runs a predicated-block FSM that applies a second condition to the next 1..`PRED_MAX` instructions. It replaces the single-bank condition unit between the Execute pipeline register and the PC/hazard logic.

## Interface
- `NBANKS`, 2: number of flag banks (≥1).
- `BW`, `$clog2(NBANKS)` (min 1): bank-select width.
- `FLUSH_CYC`, 2: instructions squashed after a taken branch (≥1).
- `PRED_MAX`, 4: maximum predicated-block length (≥1).
- `PLW`, `$clog2(PRED_MAX+1)`: predicated-length field width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `StallE` in 1: Execute stalled; no state change, all write/branch outputs 0.
- `ValidE` in 1: the Execute slot holds a real instruction.
- `CondE` in 4: condition code.
- `BankE` in BW: flag bank that is read and written.
- `FlagWE` in 2: [1] writes N,Z; [0] writes C,V.
- `NoWriteE`, `BranchE`, `MemWriteE`, `RegWriteE` in 1 each: decoded controls.
- `AluFlags` in 4: {N,Z,C,V} from the ALU.
- `PredStartE` in 1: the instruction opens a predicated block.
- `PredLenE` in PLW: block length.
- `PredCondE` in 4: block condition.
- `PCSrcE` out 1: take branch.
- `RegWE` out 1: register-file write enable.
- `MemWE` out 1: data-memory write enable.
- `FlushD` out 1: flush Fetch/Decode; equals `PCSrcE`.
- `FlagsE` out 4: current contents of bank `BankE`.
- `PredActive` out 1: predicated-block FSM is in ACTIVE.

## Operation
- Condition encoding:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL = 1; 15 NV = 0.
- `ok = CondEx(CondE, bank[BankE]) & (PredActive ? CondEx(PredCond, bank[BankE]) : 1)`.
- `ex = ValidE & !StallE & (squash_cnt==0) & ok`.
- Write and branch outputs:
  - `PCSrcE = ex & BranchE`.
  - `RegWE = ex & RegWriteE & !NoWriteE`.
  - `MemWE = ex & MemWriteE`.
- Flag write happens only when `ex`: bank[BankE] N,Z ← AluFlags[3:2] if FlagWE[1]; C,V ← AluFlags[1:0] if FlagWE[0]. Other banks are untouched.
- Squash counter:
  - Loads `FLUSH_CYC` when `PCSrcE`.
  - Otherwise decrements on each non-stalled cycle while nonzero.
  - Holds while stalled.
- Predicated-block FSM, states IDLE and ACTIVE:
  - IDLE→ACTIVE when `ex & PredStartE & PredLenE!=0`. Latch `PredCond`; `pcnt = min(PredLenE, PRED_MAX)`. The opening instruction is not itself predicated by `PredCondE`.
  - `PredStartE` with `PredLenE==0` is a no-op.
  - In ACTIVE, each `ValidE & !StallE & squash_cnt==0` instruction decrements `pcnt`, whether it passes or fails the predicate. Squashed and invalid slots do not count.
  - ACTIVE→IDLE when `pcnt` decrements from 1, or on `PCSrcE` (abort). A branch inside the block consumes its slot and ends the block.
  - `PredStartE` while ACTIVE is ignored apart from counting as a member.

## Timing
- All outputs are combinational from inputs and state; zero-cycle latency.
- A flag write is visible to the condition evaluation of the next cycle's instruction. There is no same-cycle bypass.
- The squash window covers exactly the next `FLUSH_CYC` non-stalled cycles after the branch cycle.
- Reset (`rst`=0, asynchronous):
  - All banks clear to 0000.
  - `squash_cnt`=0, FSM in IDLE, `pcnt`=0, `PredCond`=0.
  - While reset is asserted, `PCSrcE`, `RegWE`, `MemWE`, `FlushD` and `PredActive` are 0.
  - `FlagsE` shows 0000 during reset.
- Reset asserted mid-block or mid-squash aborts both immediately.
- A stall in any state freezes all registers; writes resume when the stall is released.

## Test plan
- Reset, then CMP sets bank0 Z=1 (FlagWE=11, AluFlags=0100) → next cycle CondE=0 with RegWriteE=1 gives RegWE=1; CondE=1 gives RegWE=0; CondE=15 always gives 0.
- Bank isolation: write N=1 into bank1 → bank0 MI (CondE=4) fails and bank1 MI passes; `FlagsE` shows 1000 for BankE=1 and 0000 for BankE=0.
- Taken branch (BranchE=1, CondE=14) → PCSrcE=FlushD=1. With FLUSH_CYC=2, the next 2 valid instructions give RegWE=0 and their flag writes are dropped; the third executes. A stall between them extends the window by one cycle.
- Predicated block PredLenE=3, PredCondE=0 (EQ) with Z=0 → PredActive=1 for 3 counted instructions and all of them are suppressed. PredActive=0 after the third. PredLenE=7 with PRED_MAX=4 clamps to 4.
- Branch taken inside an active block → PredActive drops next cycle and the squash window starts. A failed-condition instruction with FlagWE=11 leaves its flags unchanged.
- Assert rst asynchronously mid-squash with the block ACTIVE → all outputs 0 and flags 0000 with no clock edge; after release the first AL instruction executes normally.

Source files
------------

// File: rtl/cond_unit_pred.sv
// Execute-stage condition unit with banked NZCV flags, a post-branch squash window
// and a predicated-block FSM that applies a second condition to the following instructions.
module cond_unit_pred #(
  parameter int NBANKS    = 2,
  parameter int BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  parameter int FLUSH_CYC = 2,
  parameter int PRED_MAX  = 4,
  parameter int PLW       = $clog2(PRED_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           StallE,
  input  logic           ValidE,
  input  logic [3:0]     CondE,
  input  logic [BW-1:0]  BankE,
  input  logic [1:0]     FlagWE,
  input  logic           NoWriteE,
  input  logic           BranchE,
  input  logic           MemWriteE,
  input  logic           RegWriteE,
  input  logic [3:0]     AluFlags,
  input  logic           PredStartE,
  input  logic [PLW-1:0] PredLenE,
  input  logic [3:0]     PredCondE,
  output logic           PCSrcE,
  output logic           RegWE,
  output logic           MemWE,
  output logic           FlushD,
  output logic [3:0]     FlagsE,
  output logic           PredActive
);

  localparam int SW = $clog2(FLUSH_CYC + 1);
  localparam logic [SW-1:0]  SQUASH_LOAD = SW'(FLUSH_CYC);
  localparam logic [PLW-1:0] PMAX        = PLW'(PRED_MAX);

  typedef enum logic {IDLE, ACTIVE} pstate_t;

  function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    {n, z, cf, v} = f;
    case (c)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = cf;
      4'd3:    r = !cf;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = cf && !z;
      4'd9:    r = !cf || z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z && (n == v);
      4'd13:   r = z || (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0]     bank_flags [NBANKS];
  logic [3:0]     cur_flags;
  logic [SW-1:0]  squash_reg;
  pstate_t        state_reg, state_next;
  logic [PLW-1:0] pcnt_reg, pcnt_next;
  logic [3:0]     pcond_reg, pcond_next;
  logic           slot_live;
  logic           pred_ok;
  logic           ex;
  logic           take;

  always_comb begin
    cur_flags = 4'b0000;
    if (int'(BankE) < NBANKS) cur_flags = bank_flags[BankE];
  end

  // A slot is "live" when it is a real, unstalled, unsquashed instruction; gated by reset
  // so that no write or branch escapes while rst is held low.
  assign slot_live = rst && ValidE && !StallE && (squash_reg == '0);
  assign pred_ok   = (state_reg == ACTIVE) ? cond_ex(pcond_reg, cur_flags) : 1'b1;
  assign ex        = slot_live && cond_ex(CondE, cur_flags) && pred_ok;
  assign take      = ex && BranchE;

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      logic [3:0] flags_reg;
      logic       sel;
      assign sel = (int'(BankE) == gi);
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          flags_reg <= 4'b0000;
        end else if (ex && sel) begin
          if (FlagWE[1]) flags_reg[3:2] <= AluFlags[3:2];
          if (FlagWE[0]) flags_reg[1:0] <= AluFlags[1:0];
        end
      end
      assign bank_flags[gi] = flags_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      squash_reg <= '0;
    end else if (!StallE) begin
      if (take)                   squash_reg <= SQUASH_LOAD;
      else if (squash_reg != '0)  squash_reg <= squash_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      pcnt_reg  <= '0;
      pcond_reg <= 4'b0000;
    end else begin
      state_reg <= state_next;
      pcnt_reg  <= pcnt_next;
      pcond_reg <= pcond_next;
    end
  end

  // The opening instruction is not predicated; every live member slot consumes one count.
  always_comb begin
    state_next = state_reg;
    pcnt_next  = pcnt_reg;
    pcond_next = pcond_reg;
    case (state_reg)
      IDLE: begin
        if (ex && PredStartE && (PredLenE != '0)) begin
          state_next = ACTIVE;
          pcond_next = PredCondE;
          pcnt_next  = (PredLenE > PMAX) ? PMAX : PredLenE;
        end
      end
      ACTIVE: begin
        if (slot_live) begin
          pcnt_next = pcnt_reg - 1'b1;
          if (take || (pcnt_reg == PLW'(1))) begin
            state_next = IDLE;
            pcnt_next  = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    PCSrcE     = take;
    FlushD     = take;
    RegWE      = ex && RegWriteE && !NoWriteE;
    MemWE      = ex && MemWriteE;
    FlagsE     = cur_flags;
    PredActive = (state_reg == ACTIVE);
  end

endmodule
